// File: rtl/neuron_pkg.sv
// Shared types and sizing helpers for the time-multiplexed neuron datapath.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Weights are Q1.7: one sign/integer bit on top of the fraction.
    localparam int FRAC_W  = 7;
    localparam int DEF_X_W = 10;
    localparam int DEF_W_W = FRAC_W + 1;

    // Full-precision accumulator width: product width plus growth for n terms.
    function automatic int acc_width(input int x_w, input int w_w, input int n);
        return x_w + w_w + $clog2(n);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Start/done handshake and operand bus between layer control and one neuron.
interface neuron_mac_seq_if
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 16,
    parameter int X_W      = DEF_X_W,
    parameter int W_W      = DEF_W_W,
    parameter int ACC_W    = acc_width(X_W, W_W, N_INPUTS)
);
    logic                    start_i;
    logic                    relu_i;
    logic [N_INPUTS*X_W-1:0] x_flat_i;
    logic [N_INPUTS*W_W-1:0] w_flat_i;
    logic                    busy_o;
    logic                    done_o;
    logic [ACC_W-1:0]        result_o;

    modport master (
        output start_i, relu_i, x_flat_i, w_flat_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, relu_i, x_flat_i, w_flat_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: signed dot product of N_INPUTS activation/weight
// pairs, one term per cycle at full precision, with optional ReLU on the result.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 16,
    parameter int X_W      = DEF_X_W,
    parameter int W_W      = DEF_W_W,
    parameter int ACC_W    = acc_width(X_W, W_W, N_INPUTS)
) (
    input logic             clk_i,
    input logic             rst_i,
    neuron_mac_seq_if.slave bus
);
    localparam int IDX_W  = idx_width(N_INPUTS);
    localparam int N_PAD  = 1 << IDX_W;
    localparam int PROD_W = X_W + W_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] result_q;
    logic                    done_q;
    logic                    relu_q;

    // Operand tables are padded to a power of two so every idx value selects
    // a real entry; the padding entries are tied to zero.
    logic [X_W-1:0] x_src [N_PAD];
    logic [W_W-1:0] w_src [N_PAD];
    logic [X_W-1:0] x_lat [N_PAD];
    logic [W_W-1:0] w_lat [N_PAD];

    logic signed [X_W:0]        x_term;
    logic signed [W_W-1:0]      w_term;
    logic signed [PROD_W-1:0]   prod;

    for (genvar k = 0; k < N_PAD; k++) begin : g_unpack
        if (k < N_INPUTS) begin : g_live
            assign x_src[k] = bus.x_flat_i[k*X_W +: X_W];
            assign w_src[k] = bus.w_flat_i[k*W_W +: W_W];
        end else begin : g_pad
            assign x_src[k] = '0;
            assign w_src[k] = '0;
        end
    end

    // NOTE: operand registers carry no reset; they are always reloaded on start
    // before being read, so a reset term would only cost flops and fanout.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && bus.start_i) begin
            x_lat  <= x_src;
            w_lat  <= w_src;
            relu_q <= bus.relu_i;
        end
    end

    // Activation is zero-extended by one bit so the multiply is signed x signed.
    assign x_term   = signed'({1'b0, x_lat[idx]});
    assign w_term   = signed'(w_lat[idx]);
    assign prod     = PROD_W'(x_term) * PROD_W'(w_term);
    assign acc_next = acc + ACC_W'(prod);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            idx      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                    // Result and done are loaded with the last term so both are
                    // visible from a register throughout the DONE cycle.
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        result_q <= (relu_q && acc_next[ACC_W-1]) ? '0 : acc_next;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench: table-driven vectors plus hand-written corner sequences,
// with a scoreboard queue checked on every done pulse.
module tb_neuron_mac_seq;
    import neuron_pkg::*;

    localparam int N   = 16;
    localparam int XW  = 10;
    localparam int WW  = 8;
    localparam int AW  = acc_width(XW, WW, N);
    localparam int AW1 = acc_width(XW, WW, 1);
    localparam int AW2 = acc_width(XW, WW, 2);

    logic clk = 1'b0;
    logic rst_m;
    logic rst_s;
    always #5 clk = ~clk;

    neuron_mac_seq_if #(.N_INPUTS(N), .X_W(XW), .W_W(WW), .ACC_W(AW))  b16 ();
    neuron_mac_seq_if #(.N_INPUTS(1), .X_W(XW), .W_W(WW), .ACC_W(AW1)) b1 ();
    neuron_mac_seq_if #(.N_INPUTS(2), .X_W(XW), .W_W(WW), .ACC_W(AW2)) b2 ();

    neuron_mac_seq #(.N_INPUTS(N), .X_W(XW), .W_W(WW), .ACC_W(AW)) dut16 (
        .clk_i(clk), .rst_i(rst_m), .bus(b16));
    neuron_mac_seq #(.N_INPUTS(1), .X_W(XW), .W_W(WW), .ACC_W(AW1)) dut1 (
        .clk_i(clk), .rst_i(rst_s), .bus(b1));
    neuron_mac_seq #(.N_INPUTS(2), .X_W(XW), .W_W(WW), .ACC_W(AW2)) dut2 (
        .clk_i(clk), .rst_i(rst_s), .bus(b2));

    typedef struct {
        logic [N*XW-1:0]    x;
        logic [N*WW-1:0]    w;
        logic               relu;
        logic signed [63:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ops = 0;
    int n_done16 = 0;
    logic signed [63:0] exp_q[$];
    int done_cyc[$];
    logic signed [63:0] last_res;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [63:0] model16(input logic [N*XW-1:0] x,
                                                   input logic [N*WW-1:0] w,
                                                   input logic relu);
        longint sum = 0;
        for (int k = 0; k < N; k++)
            sum += longint'(x[k*XW +: XW]) * longint'($signed(w[k*WW +: WW]));
        if (relu && sum < 0) sum = 0;
        return sum;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (b16.done_o === 1'b1) begin
            n_done16++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("extra_done", 1, 0);
            else check("sb_result", $signed(b16.result_o), exp_q.pop_front());
        end
    end

    // Starts one N=16 operation in the current cycle and follows it to done.
    // With scramble set, inputs are randomised and start is pulsed while busy.
    task automatic do_op16(input logic [N*XW-1:0] x, input logic [N*WW-1:0] w,
                           input logic relu, input logic signed [63:0] exp,
                           input bit scramble);
        int lat;
        int busy_cnt;
        b16.x_flat_i = x;
        b16.w_flat_i = w;
        b16.relu_i   = relu;
        b16.start_i  = 1'b1;
        exp_q.push_back(exp);
        n_ops++;
        @(posedge clk); #1;
        b16.start_i = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < 4*N && lat < 0; k++) begin
            if (b16.busy_o === 1'b1) busy_cnt++;
            if (b16.done_o === 1'b1) begin
                lat = k;
            end else begin
                check("hold", $signed(b16.result_o), last_res);
                if (scramble) begin
                    b16.x_flat_i = {$urandom, $urandom, $urandom, $urandom, $urandom};
                    b16.w_flat_i = {$urandom, $urandom, $urandom, $urandom};
                    b16.relu_i   = 1'(~relu);
                    b16.start_i  = (k % 3 == 0);
                end
                @(posedge clk); #1;
            end
        end
        b16.start_i = 1'b0;
        check("latency", lat, N);
        check("busy_cycles", busy_cnt, N + 1);
        check("result", $signed(b16.result_o), exp);
        last_res = exp;
        @(posedge clk); #1;
        check("busy_after_done", b16.busy_o, 0);
        check("done_single", b16.done_o, 0);
    endtask

    task automatic wait_small(output int l1, output int l2);
        l1 = -1;
        l2 = -1;
        for (int k = 0; k < 20 && (l1 < 0 || l2 < 0); k++) begin
            if (b1.done_o === 1'b1 && l1 < 0) l1 = k;
            if (b2.done_o === 1'b1 && l2 < 0) l2 = k;
            @(posedge clk); #1;
        end
    endtask

    task automatic start_small();
        b1.start_i = 1'b1;
        b2.start_i = 1'b1;
        @(posedge clk); #1;
        b1.start_i = 1'b0;
        b2.start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        logic [N*XW-1:0] rx;
        logic [N*WW-1:0] rw;
        int l1, l2;

        rst_m = 1'b0;
        rst_s = 1'b0;
        b16.start_i = 1'b0; b16.relu_i = 1'b0; b16.x_flat_i = '0; b16.w_flat_i = '0;
        b1.start_i  = 1'b0; b1.relu_i  = 1'b0; b1.x_flat_i  = '0; b1.w_flat_i  = '0;
        b2.start_i  = 1'b0; b2.relu_i  = 1'b0; b2.x_flat_i  = '0; b2.w_flat_i  = '0;
        last_res = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", $signed(b16.result_o), 0);
        check("rst_done", b16.done_o, 0);
        check("rst_busy", b16.busy_o, 0);
        rst_m = 1'b1;
        rst_s = 1'b1;

        for (int i = 0; i < 9; i++) begin
            vecs[i].x = '0;
            vecs[i].w = '0;
            vecs[i].relu = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            vecs[0].x[k*XW +: XW] = 10'd100;  vecs[0].w[k*WW +: WW] = 8'h40;
            vecs[3].x[k*XW +: XW] = 10'd1023; vecs[3].w[k*WW +: WW] = 8'h7F;
            vecs[4].x[k*XW +: XW] = 10'd1023; vecs[4].w[k*WW +: WW] = 8'h80;
            vecs[5].x[k*XW +: XW] = 10'd1023; vecs[5].w[k*WW +: WW] = 8'h80;
            vecs[6].x[k*XW +: XW] = XW'(k);   vecs[6].w[k*WW +: WW] = WW'(k - 8);
            vecs[7].x[k*XW +: XW] = XW'(k);   vecs[7].w[k*WW +: WW] = WW'(8 - k);
            vecs[8].x[k*XW +: XW] = XW'(k);   vecs[8].w[k*WW +: WW] = WW'(8 - k);
        end
        vecs[1].x[XW-1:0] = 10'd1023; vecs[1].w[WW-1:0] = 8'h80;
        vecs[2].x[XW-1:0] = 10'd1023; vecs[2].w[WW-1:0] = 8'h80;
        vecs[2].relu = 1'b1;
        vecs[5].relu = 1'b1;
        vecs[8].relu = 1'b1;
        vecs[0].exp = 102400;
        vecs[1].exp = -130944;
        vecs[2].exp = 0;
        vecs[3].exp = 2078736;
        vecs[4].exp = -2095104;
        vecs[5].exp = 0;
        vecs[6].exp = 280;
        vecs[7].exp = -280;
        vecs[8].exp = 0;

        for (int i = 0; i < 9; i++)
            do_op16(vecs[i].x, vecs[i].w, vecs[i].relu, vecs[i].exp, 1'b0);

        // Back-to-back: second start in the cycle right after the first done.
        done_cyc.delete();
        do_op16(vecs[0].x, vecs[0].w, 1'b0, 102400, 1'b0);
        do_op16(vecs[6].x, vecs[6].w, 1'b0, 280, 1'b0);
        if (done_cyc.size() == 2) check("b2b_spacing", done_cyc[1] - done_cyc[0], N + 2);
        else check("b2b_done_count", done_cyc.size(), 2);

        // Input isolation with random operands and ignored start pulses.
        for (int r = 0; r < 3; r++) begin
            rx = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rw = {$urandom, $urandom, $urandom, $urandom};
            do_op16(rx, rw, 1'(r == 1), model16(rx, rw, 1'(r == 1)), 1'b1);
        end

        // Reset in the middle of an accumulation, then a fresh operation.
        b16.x_flat_i = vecs[3].x;
        b16.w_flat_i = vecs[3].w;
        b16.start_i  = 1'b1;
        @(posedge clk); #1;
        b16.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_result", $signed(b16.result_o), 0);
        check("midrst_done", b16.done_o, 0);
        check("midrst_busy", b16.busy_o, 0);
        rst_m = 1'b1;
        last_res = 0;
        @(posedge clk); #1;
        check("midrst_idle", b16.busy_o, 0);
        for (int k = 0; k < N; k++) begin
            rx[k*XW +: XW] = 10'd1;
            rw[k*WW +: WW] = 8'h01;
        end
        do_op16(rx, rw, 1'b0, 16, 1'b0);

        // Boundary builds: N_INPUTS=1 and N_INPUTS=2.
        b1.x_flat_i = 10'd1023;             b1.w_flat_i = 8'h80;
        b2.x_flat_i = {10'd7, 10'd1023};    b2.w_flat_i = {8'h7F, 8'h80};
        b1.relu_i = 1'b0;
        b2.relu_i = 1'b0;
        start_small();
        wait_small(l1, l2);
        check("n1_latency", l1, 1);
        check("n2_latency", l2, 2);
        check("n1_result", $signed(b1.result_o), -130944);
        check("n2_result", $signed(b2.result_o), -130055);
        b1.relu_i = 1'b1;
        b2.relu_i = 1'b1;
        start_small();
        wait_small(l1, l2);
        check("n1_relu", $signed(b1.result_o), 0);
        check("n2_relu", $signed(b2.result_o), 0);

        b1.relu_i = 1'b0;
        b2.relu_i = 1'b0;
        b1.x_flat_i = 10'd1023;          b1.w_flat_i = 8'h7F;
        b2.x_flat_i = {10'd1023, 10'd1023}; b2.w_flat_i = {8'h7F, 8'h7F};
        start_small();
        rst_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("n1_rst_busy", b1.busy_o, 0);
        check("n2_rst_busy", b2.busy_o, 0);
        check("n1_rst_done", b1.done_o, 0);
        check("n2_rst_result", $signed(b2.result_o), 0);
        rst_s = 1'b1;
        b1.x_flat_i = 10'd1;             b1.w_flat_i = 8'h01;
        b2.x_flat_i = {10'd1, 10'd1};    b2.w_flat_i = {8'h01, 8'h01};
        start_small();
        wait_small(l1, l2);
        check("n1_fresh", $signed(b1.result_o), 1);
        check("n2_fresh", $signed(b2.result_o), 2);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);
        check("done_count", n_done16, n_ops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Parametrised, time-multiplexed neuron for the network datapath. It computes the signed dot product of N_INPUTS unsigned activations and N_INPUTS signed Q1.7 weights, accumulating one term per cycle at full precision with an optional ReLU. It replaces the fixed two-input output neuron and serves both hidden and output layers. Layer control drives it with a start/done handshake.

## Interface
- N_INPUTS, 16, number of terms per dot product (≥1)
- X_W, 10, activation width, unsigned
- W_W, 8, weight width, signed Q1.7
- ACC_W, X_W+W_W+$clog2(N_INPUTS) (22), accumulator/result width, signed, 7 fractional bits
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  request; sampled only in IDLE
- relu_i  in  1  sampled with start_i; 1 = clamp negative result to 0
- x_flat_i  in  N_INPUTS*X_W  activations; x[k] = bits [k*X_W +: X_W]
- w_flat_i  in  N_INPUTS*W_W  weights; w[k] = bits [k*W_W +: W_W]
- busy_o  out  1  high in MAC and DONE
- done_o  out  1  one-cycle pulse when result_o updates
- result_o  out  ACC_W  signed result, held until the next done_o

## Operation
- States: IDLE, MAC, DONE.
- IDLE:
  - On start_i=1, latch x_flat_i, w_flat_i and relu_i into internal registers.
  - Clear acc and set idx=0, then go to MAC.
  - Inputs may change freely after the start cycle.
- MAC:
  - Each cycle: acc <= acc + sext(x[idx]) * w[idx], idx <= idx+1.
  - After the term with idx=N_INPUTS-1, go to DONE.
- DONE:
  - result_o <= (relu && acc<0) ? 0 : acc.
  - done_o=1 for exactly this cycle, then go to IDLE.
- start_i outside IDLE is ignored (not queued).
- Arithmetic:
  - x is zero-extended by one bit to signed.
  - Product is signed, X_W+W_W bits, sign-extended to ACC_W.
  - ACC_W cannot overflow for the default sizing. Any smaller ACC_W override wraps two's-complement; no saturation.
- idx width: max(1, $clog2(N_INPUTS)). With N_INPUTS=1, MAC lasts one cycle.
- Reset (rst_i=0 at a clock edge, any state):
  - State returns to IDLE.
  - acc=0, idx=0, result_o=0, done_o=0, busy_o=0.
  - Latched operands are don't-care.

## Timing
- Start sampled at edge 0. MAC occupies cycles 1..N_INPUTS. done_o and the new result_o are visible in cycle N_INPUTS+1.
- Latency from start to done is N_INPUTS+1 cycles. busy_o is high for exactly N_INPUTS+1 cycles.
- Minimum start-to-start interval is N_INPUTS+2 cycles: start may be accepted in the cycle after done_o.
- All outputs are registered. busy_o may be decoded from the state register.
- result_o changes only in the done_o cycle or on reset.

## Structure
- Shared package neuron_pkg:
  - state enum (IDLE/MAC/DONE)
  - default widths X_W=10, W_W=8, FRAC_W=7
  - function computing ACC_W from X_W, W_W and N_INPUTS
- No sub-module. The single multiplier, adder, index counter and FSM are inline. Operand selection is an idx-indexed mux over the latched vectors.

## Test plan
- Reset: hold rst_i=0 for 3 cycles mid-MAC. Then result_o=0, done_o=0, busy_o=0, and the FSM is in IDLE.
- Basic (N=16): all x=100, all w=0x40 (+0.5), relu=0. Expect done_o at cycle 17 and result_o=16*100*64=102400.
- Signed/ReLU: x0=1023, w0=0x80 (−1.0), others 0.
  - relu=0 gives result_o=−130944.
  - relu=1 gives result_o=0.
  - Previous result_o holds until done_o.
- Input isolation: change x_flat_i/w_flat_i every cycle after start. Result must equal the dot product of the start-cycle values. start_i pulses during busy are ignored, with no extra done_o.
- Back-to-back: assert start_i in the cycle after done_o. The second done_o arrives exactly N+2 cycles after the first.
- Reset mid-operation, then start: a fresh start with all x=1, w=0x01 gives result_o=16, with no residue from the aborted accumulation. Repeat with N_INPUTS=1 and N_INPUTS=2 builds to check the boundaries.
